// File: rtl/coax_pkg.sv
// Shared definitions for the coax receive packer: record tags, FSM states,
// the record layout and helpers that split a record into its two bytes.
package coax_pkg;

    localparam int         COUNT_W   = 10;
    localparam logic [9:0] COUNT_MAX = 10'd1023;

    localparam logic [1:0] TAG_DATA  = 2'b00;
    localparam logic [1:0] TAG_ERROR = 2'b01;
    localparam logic [1:0] TAG_EOF   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_BYTE0      = 2'd1,
        ST_BYTE1      = 2'd2,
        ST_ERROR_HOLD = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0]         tag;
        logic [COUNT_W-1:0] payload;
    } record_t;

    // First byte on the wire: tag in the top bits, payload MSBs at the bottom.
    function automatic logic [7:0] record_byte0(record_t r);
        return {r.tag, 4'b0000, r.payload[9:8]};
    endfunction

    // Second byte on the wire: payload LSBs.
    function automatic logic [7:0] record_byte1(record_t r);
        return r.payload[7:0];
    endfunction

endpackage

// File: rtl/coax_rx_packer_if.sv
// Bundles the FIFO-side read interface and the byte-wide output stream.
// master = the packer, slave = the FIFO/host environment around it.
interface coax_rx_packer_if;
    import coax_pkg::*;

    logic                rx_active;
    logic                rx_error;
    logic [COUNT_W-1:0]  rx_data;
    logic                rx_empty;
    logic                rx_read_strobe;
    logic [7:0]          out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;

    modport master (
        input  rx_active, rx_error, rx_data, rx_empty, out_ready,
        output rx_read_strobe, out_data, out_valid, out_last
    );

    modport slave (
        output rx_active, rx_error, rx_data, rx_empty, out_ready,
        input  rx_read_strobe, out_data, out_valid, out_last
    );
endinterface

// File: rtl/coax_eof_detector.sv
// Decides when an end-of-frame record is owed: detects the falling edge of
// rx_active, holds eof_pending, and times how long the receiver has been
// quiet with an empty buffer before the EOF may go out.
module coax_eof_detector
    import coax_pkg::*;
#(
    parameter int EMIT_EOF    = 1,
    parameter int FLUSH_DELAY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_active_i,
    input  logic rx_empty_i,
    input  logic has_data_i,
    input  logic clear_i,
    output logic eof_pending_o,
    output logic flush_expired_o
);

    localparam logic [7:0] FLUSH_LIMIT = 8'(FLUSH_DELAY);

    logic       active_prev_q;
    logic       pending_q, pending_d;
    logic [7:0] timer_q, timer_d;
    logic       active_fall;
    logic       quiet;

    assign active_fall = active_prev_q && !rx_active_i;
    assign quiet       = !rx_active_i && rx_empty_i;

    // A frame end only owes an EOF if something was received in that frame.
    always_comb begin
        pending_d = pending_q;
        if (clear_i) begin
            pending_d = 1'b0;
        end else if ((EMIT_EOF != 0) && active_fall && (has_data_i || !rx_empty_i)) begin
            pending_d = 1'b1;
        end
    end

    // Flush timer restarts whenever the receiver wakes up or the buffer refills.
    always_comb begin
        timer_d = '0;
        if (pending_q && !clear_i && quiet) begin
            timer_d = (timer_q == FLUSH_LIMIT) ? timer_q : timer_q + 8'd1;
        end
    end

    // Edge-detect register, pending flag and timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_prev_q <= 1'b0;
            pending_q     <= 1'b0;
            timer_q       <= '0;
        end else begin
            active_prev_q <= rx_active_i;
            pending_q     <= pending_d;
            timer_q       <= timer_d;
        end
    end

    assign eof_pending_o   = pending_q;
    assign flush_expired_o = pending_q && (timer_q == FLUSH_LIMIT);

endmodule

// File: rtl/coax_rx_packer.sv
// Drains 10-bit words from the receiver FIFO and serialises each into a
// two-byte record (DATA, ERROR or EOF) on a valid/ready byte stream.
// Optional macro COAX_RX_PACKER_COUNT_EN: when defined, EOF records carry the
// saturating count of DATA records since the last EOF/error/reset; otherwise
// the counter is not built and the EOF payload is zero.
module coax_rx_packer
    import coax_pkg::*;
#(
    parameter int EMIT_EOF    = 1,
    parameter int FLUSH_DELAY = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    coax_rx_packer_if.master        bus
);

    state_t             state_q, state_d;
    record_t            rec_q, rec_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               has_data_q, has_data_d;
    logic               pop;
    logic               eof_clear;
    logic               count_clear;
    logic               eof_pending;
    logic               flush_expired;
    logic               handshake;
    logic [COUNT_W-1:0] eof_payload;

    assign handshake = out_valid_q && bus.out_ready;

    coax_eof_detector #(
        .EMIT_EOF    (EMIT_EOF),
        .FLUSH_DELAY (FLUSH_DELAY)
    ) u_eof_detector (
        .clk             (clk),
        .reset           (reset),
        .rx_active_i     (bus.rx_active),
        .rx_empty_i      (bus.rx_empty),
        .has_data_i      (has_data_q),
        .clear_i         (eof_clear),
        .eof_pending_o   (eof_pending),
        .flush_expired_o (flush_expired)
    );

`ifdef COAX_RX_PACKER_COUNT_EN
    logic [COUNT_W-1:0] count_q, count_d;

    // Saturating DATA-record count reported in the next EOF.
    always_comb begin
        count_d = count_q;
        if (count_clear) begin
            count_d = '0;
        end else if (pop && (count_q != COUNT_MAX)) begin
            count_d = count_q + 10'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign eof_payload = count_q;
`else
    assign eof_payload = '0;
`endif

    // Tracks whether any word was popped since the last EOF/error, so the
    // EOF decision works even when the counter is not built.
    always_comb begin
        has_data_d = has_data_q;
        if (count_clear) begin
            has_data_d = 1'b0;
        end else if (pop) begin
            has_data_d = 1'b1;
        end
    end

    // Packer FSM: record selection in IDLE, then two output bytes.
    always_comb begin
        state_d     = state_q;
        rec_d       = rec_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        pop         = 1'b0;
        eof_clear   = 1'b0;
        count_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_error) begin
                    rec_d       = '{tag: TAG_ERROR, payload: bus.rx_data};
                    eof_clear   = 1'b1;
                    count_clear = 1'b1;
                    state_d     = ST_BYTE0;
                end else if (!bus.rx_empty) begin
                    rec_d   = '{tag: TAG_DATA, payload: bus.rx_data};
                    pop     = 1'b1;
                    state_d = ST_BYTE0;
                end else if (eof_pending && flush_expired) begin
                    rec_d       = '{tag: TAG_EOF, payload: eof_payload};
                    eof_clear   = 1'b1;
                    count_clear = 1'b1;
                    state_d     = ST_BYTE0;
                end
                if (state_d == ST_BYTE0) begin
                    out_valid_d = 1'b1;
                    out_data_d  = record_byte0(rec_d);
                    out_last_d  = 1'b0;
                end
            end
            ST_BYTE0: begin
                if (handshake) begin
                    state_d    = ST_BYTE1;
                    out_data_d = record_byte1(rec_q);
                    out_last_d = (rec_q.tag != TAG_DATA);
                end
            end
            ST_BYTE1: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                    out_last_d  = 1'b0;
                    state_d     = (rec_q.tag == TAG_ERROR) ? ST_ERROR_HOLD : ST_IDLE;
                end
            end
            ST_ERROR_HOLD: begin
                if (!bus.rx_error) begin
                    count_clear = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                out_data_d  = '0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // State, latched record and registered output stream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rec_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            has_data_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rec_q       <= rec_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            has_data_q  <= has_data_d;
        end
    end

    assign bus.rx_read_strobe = pop && !reset;
    assign bus.out_data       = out_data_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_last       = out_last_q;

endmodule

// File: tb/tb_coax_rx_packer.sv
// Testbench for coax_rx_packer: a queue-based FIFO model feeds the DUT and a
// queue of expected {last, byte} entries is built from the record rules.
`timescale 1ns/1ps
module tb_coax_rx_packer;

    localparam int FLUSH = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    coax_rx_packer_if bus();

    coax_rx_packer #(
        .EMIT_EOF    (1),
        .FLUSH_DELAY (FLUSH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [9:0] fifoQ[$];
    logic [8:0] expQ[$];
    int         frameCount  = 0;
    int         strobeCount = 0;
    logic       strobeSeen  = 1'b0;
    logic       rxError     = 1'b0;
    logic [9:0] errCode     = 10'h000;
    logic       randReady   = 1'b0;
    logic       silentCheck = 1'b0;
    logic       stallPrev   = 1'b0;
    logic [7:0] dataPrev    = 8'h00;

    // EOF payload expected for a frame of n words.
    function automatic logic [9:0] eofPayload(int n);
`ifdef COAX_RX_PACKER_COUNT_EN
        return (n > 1023) ? 10'd1023 : 10'(n);
`else
        return 10'd0;
`endif
    endfunction

    task automatic driveRx();
        bus.rx_error = rxError;
        bus.rx_empty = (fifoQ.size() == 0);
        if (rxError)
            bus.rx_data = errCode;
        else if (fifoQ.size() > 0)
            bus.rx_data = fifoQ[0];
        else
            bus.rx_data = 10'h000;
    endtask

    task automatic expectRecord(input logic [1:0] tag, input logic [9:0] payload, input logic last);
        logic [7:0] b0;
        b0 = {tag, 4'b0000, payload[9:8]};
        expQ.push_back({1'b0, b0});
        expQ.push_back({last, payload[7:0]});
    endtask

    task automatic pushWord(input logic [9:0] w);
        fifoQ.push_back(w);
        frameCount++;
        expectRecord(2'b00, w, 1'b0);
        driveRx();
    endtask

    // Observe the DUT at the falling edge, well away from the active edge.
    task automatic checkOutput();
        logic [8:0] got;
        logic [8:0] want;
        @(negedge clk);
        strobeSeen = bus.rx_read_strobe;
        if (strobeSeen) begin
            strobeCount++;
            vectors++;
            assert (!bus.rx_empty && !bus.rx_error && !reset) else begin
                miscompares++;
                $error("FAIL strobe_legal observed empty=%b error=%b expected both 0", bus.rx_empty, bus.rx_error);
            end
        end
        if (stallPrev) begin
            vectors++;
            assert (bus.out_valid === 1'b1 && bus.out_data === dataPrev) else begin
                miscompares++;
                $error("FAIL stall_hold observed valid=%b data=%h expected valid=1 data=%h", bus.out_valid, bus.out_data, dataPrev);
            end
        end
        if (silentCheck) begin
            vectors++;
            assert (bus.out_valid === 1'b0 && !strobeSeen) else begin
                miscompares++;
                $error("FAIL error_silence observed valid=%b strobe=%b expected 0 0", bus.out_valid, strobeSeen);
            end
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            got  = {bus.out_last, bus.out_data};
            want = (expQ.size() > 0) ? expQ[0] : 9'h1FF;
            vectors++;
            assert (expQ.size() > 0 && got === want) else begin
                miscompares++;
                $error("FAIL stream_byte observed last=%b data=%h expected last=%b data=%h (pending=%0d)", got[8], got[7:0], want[8], want[7:0], expQ.size());
            end
            if (expQ.size() > 0) void'(expQ.pop_front());
        end
        stallPrev = (bus.out_valid === 1'b1 && bus.out_ready === 1'b0);
        dataPrev  = bus.out_data;
    endtask

    // Advance to just after the rising edge and update the FIFO model.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (strobeSeen && fifoQ.size() > 0) void'(fifoQ.pop_front());
        strobeSeen = 1'b0;
        if (randReady) bus.out_ready = ($urandom_range(0, 99) < 70);
        driveRx();
    endtask

    task automatic tick();
        checkOutput();
        applyStimulus();
    endtask

    task automatic startFrame();
        bus.rx_active = 1'b1;
        tick();
        tick();
    endtask

    task automatic endFrame();
        bus.rx_active = 1'b0;
        if (frameCount > 0) expectRecord(2'b10, eofPayload(frameCount), 1'b1);
        frameCount = 0;
    endtask

    task automatic waitDrain(input int budget, input string name, input logic needFifoEmpty);
        int n;
        n = 0;
        while ((expQ.size() != 0 || (needFifoEmpty && fifoQ.size() != 0)) && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        assert (expQ.size() == 0 && (!needFifoEmpty || fifoQ.size() == 0)) else begin
            miscompares++;
            $error("FAIL %s observed %0d bytes outstanding expected 0", name, expQ.size());
        end
        repeat (FLUSH + 6) tick();
    endtask

    initial begin
        int s0;
        int n;
        reset         = 1'b1;
        bus.rx_active = 1'b0;
        bus.out_ready = 1'b0;
        fifoQ.push_back(10'h111);
        driveRx();
        repeat (3) tick();

        $display("[TB] reset state");
        vectors += 4;
        assert (bus.out_valid === 1'b0) else begin
            miscompares++; $error("FAIL reset_valid observed %b expected 0", bus.out_valid);
        end
        assert (bus.out_data === 8'h00) else begin
            miscompares++; $error("FAIL reset_data observed %h expected 00", bus.out_data);
        end
        assert (bus.out_last === 1'b0) else begin
            miscompares++; $error("FAIL reset_last observed %b expected 0", bus.out_last);
        end
        assert (bus.rx_read_strobe === 1'b0) else begin
            miscompares++; $error("FAIL reset_strobe observed %b expected 0", bus.rx_read_strobe);
        end
        fifoQ.delete();
        driveRx();
        reset = 1'b0;
        repeat (2) tick();

        $display("[TB] data drain");
        startFrame();
        bus.out_ready = 1'b1;
        s0 = strobeCount;
        pushWord(10'h2A5);
        pushWord(10'h013);
        waitDrain(50, "drain_timeout", 1'b1);
        vectors++;
        assert (strobeCount - s0 == 2) else begin
            miscompares++; $error("FAIL drain_strobes observed %0d expected 2", strobeCount - s0);
        end
        endFrame();
        waitDrain(50, "drain_eof_timeout", 1'b1);

        $display("[TB] backpressure");
        startFrame();
        bus.out_ready = 1'b0;
        pushWord(10'h3FF);
        pushWord(10'h155);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        s0 = strobeCount;
        repeat (5) tick();
        vectors += 2;
        assert (strobeCount == s0) else begin
            miscompares++; $error("FAIL stall_no_pop observed %0d pops expected 0", strobeCount - s0);
        end
        assert (bus.out_valid === 1'b1 && bus.out_data === 8'h03) else begin
            miscompares++; $error("FAIL stall_byte0 observed valid=%b data=%h expected 1 03", bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        endFrame();
        waitDrain(100, "stall_timeout", 1'b1);

        $display("[TB] three-word frame with EOF");
        startFrame();
        for (int i = 0; i < 3; i++) begin
            pushWord(10'($urandom_range(0, 1023)));
            tick();
        end
        endFrame();
        waitDrain(100, "eof3_timeout", 1'b1);

        $display("[TB] random frames");
        for (int f = 0; f < 6; f++) begin
            startFrame();
            randReady = 1'b1;
            n = $urandom_range(0, 20);
            for (int i = 0; i < n; i++) begin
                pushWord(10'($urandom_range(0, 1023)));
                repeat ($urandom_range(0, 3)) tick();
            end
            endFrame();
            waitDrain(2000, "random_timeout", 1'b1);
            randReady     = 1'b0;
            bus.out_ready = 1'b1;
            tick();
        end

        $display("[TB] count saturation");
        startFrame();
        for (int i = 0; i < 1100; i++) pushWord(10'($urandom_range(0, 1023)));
        endFrame();
        waitDrain(4000, "saturate_timeout", 1'b1);

        $display("[TB] reset during second byte");
        startFrame();
        pushWord(10'h1C3);
        n = 0;
        while (expQ.size() > 1 && n < 20) begin
            tick();
            n++;
        end
        bus.out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        vectors++;
        assert (bus.out_valid === 1'b0) else begin
            miscompares++; $error("FAIL async_reset_valid observed %b expected 0", bus.out_valid);
        end
        expQ.delete();
        fifoQ.delete();
        frameCount = 0;
        stallPrev  = 1'b0;
        driveRx();
        repeat (2) tick();
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        pushWord(10'h2E7);
        tick();
        tick();
        endFrame();
        waitDrain(100, "post_reset_timeout", 1'b1);

        $display("[TB] error priority");
        s0      = strobeCount;
        rxError = 1'b1;
        errCode = 10'h008;
        fifoQ.push_back(10'h155);
        expectRecord(2'b01, 10'h008, 1'b1);
        driveRx();
        waitDrain(50, "error_timeout", 1'b0);
        silentCheck = 1'b1;
        repeat (20) tick();
        silentCheck = 1'b0;
        vectors++;
        assert (strobeCount == s0) else begin
            miscompares++; $error("FAIL error_no_pop observed %0d pops expected 0", strobeCount - s0);
        end

        reset   = 1'b1;
        rxError = 1'b0;
        fifoQ.delete();
        driveRx();
        repeat (2) tick();
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
